input_conditioner: RTL and testbench

Front-end stage feeding the car control FSM. It synchronises and debounces the three raw push-buttons (left, right, centre) into clean levels, and produces a one-cycle restart pulse on the centre button. It also runs the free-running 8-bit LFSR that supplies `random_num` for rival-car spawn positions. Its outputs connect directly to the FSM's `BTNL`, `BTNR`, `BTNC` and `random_num` inputs.

---
 rtl/road_fighter_pkg.sv | 24 ++
 rtl/debounce_channel.sv | 61 ++++++
 rtl/input_conditioner.sv | 85 ++++++++
 tb/tb_input_conditioner.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/road_fighter_pkg.sv
// Shared constants for the road-fighter front end.
// Holds the system clock rate, the default debounce length and the LFSR
// geometry, plus helpers for advancing the LFSR and sanitising its seed.
package road_fighter_pkg;

    localparam int unsigned CLK_HZ                  = 100_000_000;
    // 10 ms at CLK_HZ
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    localparam int unsigned         LFSR_W    = 8;
    // Taps 7,5,4,3: x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [LFSR_W-1:0]   LFSR_TAPS = 8'hB8;

    // Fibonacci step: XOR of tapped bits is shifted in at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
        return {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
    endfunction

    // The all-zero state is a lock-up state, so a zero seed is replaced by 1.
    function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? LFSR_W'(1) : seed;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: two-flop synchroniser followed by a counter-based
// debouncer. The output level only changes after the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   raw   - asynchronous button input, active high
//   level - debounced level (registered)
module debounce_channel
    import road_fighter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned      CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            db_q, db_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        db_d  = db_q;
        cnt_d = cnt_q;
        if (s2_q == db_q) begin
            // Agreement (including a glitch back) restarts the count.
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = db_q;

endmodule

// File: rtl/input_conditioner.sv
// Front-end stage for the car control FSM. Debounces the left, right and
// centre buttons, produces a one-cycle restart strobe on the centre button's
// rising edge, and runs the free-running LFSR used for rival spawn positions.
//
// Ports:
//   clk        - 100 MHz system clock
//   rst        - synchronous active-high reset
//   btn_l_raw  - raw left button
//   btn_r_raw  - raw right button
//   btn_c_raw  - raw centre button
//   btnl       - debounced left level
//   btnr       - debounced right level
//   btnc       - debounced centre level
//   btnc_pulse - one-cycle strobe on btnc rising
//   random_num - current LFSR state
module input_conditioner
    import road_fighter_pkg::*;
#(
    parameter int unsigned        DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [LFSR_W-1:0] LFSR_SEED       = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_l_raw,
    input  logic              btn_r_raw,
    input  logic              btn_c_raw,
    output logic              btnl,
    output logic              btnr,
    output logic              btnc,
    output logic              btnc_pulse,
    output logic [LFSR_W-1:0] random_num
);

    localparam logic [LFSR_W-1:0] SeedEff = lfsr_seed_fix(LFSR_SEED);

    logic              btnc_q, btnc_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_l (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_l_raw),
        .level (btnl)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_r (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_r_raw),
        .level (btnr)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_c (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_c_raw),
        .level (btnc)
    );

    always_comb begin
        btnc_d = btnc;
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btnc_q <= 1'b0;
            lfsr_q <= SeedEff;
        end else begin
            btnc_q <= btnc_d;
            lfsr_q <= lfsr_d;
        end
    end

    // Both terms are flops, so the strobe has no path from the raw pins.
    assign btnc_pulse = btnc & ~btnc_q;
    assign random_num = lfsr_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int         DB   = 4;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_l_raw = 1'b0;
    logic       btn_r_raw = 1'b0;
    logic       btn_c_raw = 1'b0;
    logic       btnl, btnr, btnc, btnc_pulse;
    logic [7:0] random_num;
    logic       btnl0, btnr0, btnc0, btnc_pulse0;
    logic [7:0] random_num0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .LFSR_SEED       (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_l_raw  (btn_l_raw),
        .btn_r_raw  (btn_r_raw),
        .btn_c_raw  (btn_c_raw),
        .btnl       (btnl),
        .btnr       (btnr),
        .btnc       (btnc),
        .btnc_pulse (btnc_pulse),
        .random_num (random_num)
    );

    // Second instance with the illegal zero seed.
    input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .LFSR_SEED       (8'h00)
    ) dut0 (
        .clk        (clk),
        .rst        (rst),
        .btn_l_raw  (btn_l_raw),
        .btn_r_raw  (btn_r_raw),
        .btn_c_raw  (btn_c_raw),
        .btnl       (btnl0),
        .btnr       (btnr0),
        .btnc       (btnc0),
        .btnc_pulse (btnc_pulse0),
        .random_num (random_num0)
    );

    // Reference model. Bit 0 = left, 1 = right, 2 = centre.
    logic [2:0] m_p1 = '0, m_p2 = '0, m_lvl = '0;
    logic       m_c_prev = 1'b0;
    logic [2:0] m_hist [$];        // synchronised values seen, most recent last
    logic [7:0] m_lfsr  = SEED;
    logic [7:0] m_lfsr0 = 8'h01;

    function automatic logic [7:0] lfsr_model(input logic [7:0] s);
        int v, fb;
        v  = int'(s);
        fb = (((v >> 7) & 1) + ((v >> 5) & 1) + ((v >> 4) & 1) + ((v >> 3) & 1)) % 2;
        return 8'(((v << 1) | fb) & 255);
    endfunction

    function automatic logic [11:0] model_vec();
        return {m_lvl[0], m_lvl[1], m_lvl[2], m_lvl[2] & ~m_c_prev, m_lfsr};
    endfunction

    // Advance one clock edge, update the model, return 1 ns after the edge.
    task automatic step();
        logic [2:0] raw_now;
        logic       c_old;
        logic       differ;
        @(posedge clk);
        raw_now = {btn_c_raw, btn_r_raw, btn_l_raw};
        if (rst) begin
            m_p1     = '0;
            m_p2     = '0;
            m_lvl    = '0;
            m_c_prev = 1'b0;
            m_hist.delete();
            m_lfsr   = (SEED == 8'h00) ? 8'h01 : SEED;
            m_lfsr0  = 8'h01;
        end else begin
            m_hist.push_back(m_p2);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            c_old = m_lvl[2];
            // Level follows once the last DB synchronised samples all disagree with it.
            if (m_hist.size() == DB) begin
                for (int ch = 0; ch < 3; ch++) begin
                    differ = 1'b1;
                    for (int i = 0; i < DB; i++)
                        if (m_hist[i][ch] == m_lvl[ch]) differ = 1'b0;
                    if (differ) m_lvl[ch] = ~m_lvl[ch];
                end
            end
            m_c_prev = c_old;
            m_p2     = m_p1;
            m_p1     = raw_now;
            m_lfsr   = lfsr_model(m_lfsr);
            m_lfsr0  = lfsr_model(m_lfsr0);
        end
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        btn_l_raw = 1'b0; btn_r_raw = 1'b0; btn_c_raw = 1'b0;
        apply_reset(3);
        checks++;
        if ({btnl, btnr, btnc, btnc_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_btns: got %b expected 0000", {btnl, btnr, btnc, btnc_pulse});
        end
        checks++;
        if (random_num !== 8'hA5) begin
            errors++;
            $display("FAIL reset_lfsr: got %h expected a5", random_num);
        end
        checks++;
        if ({btnl0, btnr0, btnc0, btnc_pulse0, random_num0} !== 12'h001) begin
            errors++;
            $display("FAIL reset_zero_seed: got %h expected 001",
                     {btnl0, btnr0, btnc0, btnc_pulse0, random_num0});
        end
        step();
        checks++;
        if (random_num !== m_lfsr || random_num === SEED) begin
            errors++;
            $display("FAIL lfsr_first_step: got %h expected %h", random_num, m_lfsr);
        end
        checks++;
        if (random_num0 !== m_lfsr0) begin
            errors++;
            $display("FAIL lfsr0_first_step: got %h expected %h", random_num0, m_lfsr0);
        end
    endtask

    task automatic test_clean_press();
        apply_reset(2);
        btn_l_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            checks++;
            if (btnl !== (e >= 6)) begin
                errors++;
                $display("FAIL clean_press_edge%0d: btnl=%b expected %b", e, btnl, e >= 6);
            end
            checks++;
            if ({btnr, btnc, btnc_pulse} !== 3'b000 || model_vec() !== {btnl, btnr, btnc,
                btnc_pulse, random_num}) begin
                errors++;
                $display("FAIL clean_press_others%0d: got %h expected %h", e,
                         {btnl, btnr, btnc, btnc_pulse, random_num}, model_vec());
            end
        end
        btn_l_raw = 1'b0;
    endtask

    task automatic test_bounce();
        apply_reset(2);
        for (int k = 0; k < 4; k++) begin
            btn_r_raw = (k % 2 == 0);
            repeat (2) begin
                step();
                checks++;
                if (btnr !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_reject: btnr=%b expected 0", btnr);
                end
            end
        end
        btn_r_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (btnr !== (e >= 6)) begin
                errors++;
                $display("FAIL bounce_rise_edge%0d: btnr=%b expected %b", e, btnr, e >= 6);
            end
        end
        btn_r_raw = 1'b0;
    endtask

    task automatic test_restart_pulse();
        int pulses;
        apply_reset(2);
        pulses    = 0;
        btn_c_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (btnc_pulse === 1'b1) pulses++;
            checks++;
            if (btnc_pulse !== (e == 6) || btnc !== (e >= 6)) begin
                errors++;
                $display("FAIL pulse_press_edge%0d: btnc=%b pulse=%b expected %b %b",
                         e, btnc, btnc_pulse, e >= 6, e == 6);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL pulse_count: got %0d expected 1", pulses);
        end
        btn_c_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (btnc_pulse !== 1'b0 || btnc !== (e < 6)) begin
                errors++;
                $display("FAIL pulse_release_edge%0d: btnc=%b pulse=%b expected %b 0",
                         e, btnc, btnc_pulse, e < 6);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        apply_reset(2);
        btn_l_raw = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (btnl !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_reset: btnl=%b expected 0", btnl);
        end
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (btnl !== (e >= 6)) begin
                errors++;
                $display("FAIL midrst_edge%0d: btnl=%b expected %b", e, btnl, e >= 6);
            end
        end
        btn_l_raw = 1'b0;
    endtask

    task automatic test_lfsr_sequence();
        bit seen [int];
        int first_rep;
        apply_reset(3);
        first_rep = -1;
        seen[int'(random_num)] = 1'b1;
        for (int k = 1; k <= 510; k++) begin
            step();
            checks++;
            if (random_num === 8'h00 || random_num !== m_lfsr) begin
                errors++;
                $display("FAIL lfsr_cycle%0d: got %h expected %h", k, random_num, m_lfsr);
            end
            if (random_num === SEED && first_rep < 0) first_rep = k;
            seen[int'(random_num)] = 1'b1;
        end
        checks++;
        if (first_rep != 255) begin
            errors++;
            $display("FAIL lfsr_period: got %0d expected 255", first_rep);
        end
        checks++;
        if (seen.num() != 255) begin
            errors++;
            $display("FAIL lfsr_distinct: got %0d expected 255", seen.num());
        end
    endtask

    task automatic test_random();
        int hold;
        apply_reset(2);
        for (int seg = 0; seg < 80; seg++) begin
            btn_l_raw = 1'($urandom_range(0, 1));
            btn_r_raw = 1'($urandom_range(0, 1));
            btn_c_raw = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 19) == 0);
            hold      = int'($urandom_range(1, 8));
            for (int h = 0; h < hold; h++) begin
                step();
                rst = 1'b0;
                checks++;
                if ({btnl, btnr, btnc, btnc_pulse, random_num} !== model_vec()) begin
                    errors++;
                    $display("FAIL random_seg%0d: got %h expected %h", seg,
                             {btnl, btnr, btnc, btnc_pulse, random_num}, model_vec());
                end
            end
        end
        btn_l_raw = 1'b0; btn_r_raw = 1'b0; btn_c_raw = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Simultaneous presses on all channels, released then re-pressed.
        apply_reset(2);
        for (int rep = 0; rep < 3; rep++) begin
            {btn_c_raw, btn_r_raw, btn_l_raw} = 3'b111;
            for (int e = 1; e <= 7; e++) begin
                step();
                checks++;
                if ({btnl, btnr, btnc, btnc_pulse, random_num} !== model_vec()) begin
                    errors++;
                    $display("FAIL b2b_press%0d_%0d: got %h expected %h", rep, e,
                             {btnl, btnr, btnc, btnc_pulse, random_num}, model_vec());
                end
            end
            {btn_c_raw, btn_r_raw, btn_l_raw} = 3'b000;
            for (int e = 1; e <= 7; e++) begin
                step();
                checks++;
                if ({btnl, btnr, btnc, btnc_pulse, random_num} !== model_vec()) begin
                    errors++;
                    $display("FAIL b2b_release%0d_%0d: got %h expected %h", rep, e,
                             {btnl, btnr, btnc, btnc_pulse, random_num}, model_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_restart_pulse();
        test_reset_mid_count();
        test_lfsr_sequence();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
